// File: rtl/pipe_stage_chain.sv
// Pipeline-register chain with per-stage valid bits, stall (hold plus bubble) and flush (kill),
// plus saturating stall/flush/bubble event counters for performance visibility.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall_req,
    input  logic [STAGES-1:0]         flush_req,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic              bubble_evt;

    // A request at stage i covers every younger stage, so each stage looks at bits >= itself.
    always_comb begin
        hold = '0;
        kill = '0;
        for (int j = 0; j < STAGES; j++) begin
            hold[j] = |(stall_req >> j);
            kill[j] = |(flush_req >> j);
        end
    end

    always_comb begin
        bubble_evt = 1'b0;
        for (int j = 1; j < STAGES; j++) begin
            if (!kill[j] && !hold[j] && valid_q[j-1] && (hold[j-1] || kill[j-1]))
                bubble_evt = 1'b1;
        end
    end

    assign in_ready = ~hold[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int j = 0; j < STAGES; j++)
                data_q[j] <= '0;
        end else begin
            if (kill[0]) begin
                valid_q[0] <= 1'b0;
            end else if (!hold[0]) begin
                valid_q[0] <= in_valid;
                data_q[0]  <= in_data;
            end
            for (int j = 1; j < STAGES; j++) begin
                if (kill[j]) begin
                    valid_q[j] <= 1'b0;
                end else if (!hold[j]) begin
                    // Advancing past a held or killed neighbour inserts a bubble; data still moves.
                    valid_q[j] <= valid_q[j-1] & ~hold[j-1] & ~kill[j-1];
                    data_q[j]  <= data_q[j-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (|stall_req && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (|flush_req && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
            if (bubble_evt && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    always_comb begin
        stage_data = '0;
        for (int j = 0; j < STAGES; j++)
            stage_data[j*WIDTH +: WIDTH] = data_q[j];
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus random traffic, all checked against
// a slot-level reference model of the pipeline.
module tb_pipe_stage_chain;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_ready;
    logic [STAGES-1:0]       stall_req;
    logic [STAGES-1:0]       flush_req;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        flush_cnt;
    logic [CNT_W-1:0]        bubble_cnt;

    pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall_req  (stall_req),
        .flush_req  (flush_req),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one slot per stage, index 0 youngest.
    logic             m_valid [STAGES];
    logic [WIDTH-1:0] m_data  [STAGES];
    int               m_stall, m_flush, m_bubble;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [STAGES-1:0] model_valid_vec();
        logic [STAGES-1:0] v;
        for (int j = 0; j < STAGES; j++) v[j] = m_valid[j];
        return v;
    endfunction

    function automatic logic [STAGES*WIDTH-1:0] model_data_vec();
        logic [STAGES*WIDTH-1:0] d;
        for (int j = 0; j < STAGES; j++) d[j*WIDTH +: WIDTH] = m_data[j];
        return d;
    endfunction

    task automatic cycle(input logic r, input logic iv, input logic [WIDTH-1:0] id,
                         input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
        logic             held [STAGES];
        logic             killed [STAGES];
        logic             nv [STAGES];
        logic [WIDTH-1:0] nd [STAGES];
        logic             bub;
        rst = r; in_valid = iv; in_data = id; stall_req = st; flush_req = fl;
        #1;
        for (int j = 0; j < STAGES; j++) begin
            held[j] = 1'b0;
            killed[j] = 1'b0;
            for (int k = j; k < STAGES; k++) begin
                if (st[k]) held[j] = 1'b1;
                if (fl[k]) killed[j] = 1'b1;
            end
        end
        check("in_ready", 128'(in_ready), 128'(!held[0]));
        bub = 1'b0;
        for (int j = 0; j < STAGES; j++) begin
            nv[j] = m_valid[j];
            nd[j] = m_data[j];
            if (killed[j]) nv[j] = 1'b0;
            else if (!held[j]) begin
                if (j == 0) begin
                    nv[j] = iv;
                    nd[j] = id;
                end else begin
                    nv[j] = m_valid[j-1] && !held[j-1] && !killed[j-1];
                    nd[j] = m_data[j-1];
                    if (m_valid[j-1] && (held[j-1] || killed[j-1])) bub = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int j = 0; j < STAGES; j++) begin
                m_valid[j] = 1'b0;
                m_data[j]  = '0;
            end
            m_stall = 0; m_flush = 0; m_bubble = 0;
        end else begin
            for (int j = 0; j < STAGES; j++) begin
                m_valid[j] = nv[j];
                m_data[j]  = nd[j];
            end
            if (st != 0 && m_stall < CMAX) m_stall++;
            if (fl != 0 && m_flush < CMAX) m_flush++;
            if (bub && m_bubble < CMAX) m_bubble++;
        end
        check("stage_valid", 128'(stage_valid), 128'(model_valid_vec()));
        check("stage_data", 128'(stage_data), 128'(model_data_vec()));
        check("out_valid", 128'(out_valid), 128'(m_valid[STAGES-1]));
        check("out_data", 128'(out_data), 128'(m_data[STAGES-1]));
        check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        check("flush_cnt", 128'(flush_cnt), 128'(m_flush));
        check("bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
    endtask

    // Stages 0..3 end up holding A, B, C, D (D oldest).
    task automatic fill_abcd();
        cycle(1'b1, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b1, 32'hDDDD_0004, '0, '0);
        cycle(1'b0, 1'b1, 32'hCCCC_0003, '0, '0);
        cycle(1'b0, 1'b1, 32'hBBBB_0002, '0, '0);
        cycle(1'b0, 1'b1, 32'hAAAA_0001, '0, '0);
    endtask

    initial begin
        m_stall = 0; m_flush = 0; m_bubble = 0;
        for (int j = 0; j < STAGES; j++) begin
            m_valid[j] = 1'b0;
            m_data[j]  = '0;
        end

        // Free flow
        cycle(1'b1, 1'b0, '0, '0, '0);
        check("reset_valid", 128'(stage_valid), 128'(0));
        cycle(1'b0, 1'b1, 32'h11, '0, '0);
        cycle(1'b0, 1'b1, 32'h22, '0, '0);
        cycle(1'b0, 1'b1, 32'h33, '0, '0);
        cycle(1'b0, 1'b0, '0, '0, '0);
        check("flow_c4", 128'({out_valid, out_data}), 128'({1'b1, 32'h11}));
        cycle(1'b0, 1'b0, '0, '0, '0);
        check("flow_c5", 128'({out_valid, out_data}), 128'({1'b1, 32'h22}));
        cycle(1'b0, 1'b0, '0, '0, '0);
        check("flow_c6", 128'({out_valid, out_data}), 128'({1'b1, 32'h33}));
        check("flow_cnts", 128'({stall_cnt, flush_cnt, bubble_cnt}), 128'(0));

        // Load-use stall
        fill_abcd();
        cycle(1'b0, 1'b1, 32'hEEEE_0005, 4'b0010, 4'b0000);
        check("lu_valid", 128'(stage_valid), 128'(4'b1011));
        check("lu_out", 128'(out_data), 128'(32'hCCCC_0003));
        check("lu_s0", 128'(stage_data[31:0]), 128'(32'hAAAA_0001));
        check("lu_cnts", 128'({stall_cnt, bubble_cnt}), 128'({4'd1, 4'd1}));

        // Branch flush
        fill_abcd();
        cycle(1'b0, 1'b1, 32'hEEEE_0005, 4'b0000, 4'b0011);
        check("bf_valid", 128'(stage_valid), 128'(4'b1000));
        check("bf_out", 128'(out_data), 128'(32'hCCCC_0003));
        check("bf_flush_cnt", 128'(flush_cnt), 128'(4'd1));

        // Stall and flush together
        fill_abcd();
        cycle(1'b0, 1'b1, 32'hEEEE_0005, 4'b0100, 4'b0001);
        check("sf_valid", 128'(stage_valid), 128'(4'b0110));
        check("sf_cnts", 128'({stall_cnt, flush_cnt}), 128'({4'd1, 4'd1}));

        // Reset mid-stream, then refill
        fill_abcd();
        cycle(1'b1, 1'b1, 32'h5555_0000, 4'b1111, 4'b0000);
        check("rst_all", 128'({stage_valid, stage_data, stall_cnt, flush_cnt, bubble_cnt}), 128'(0));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h7000_0000 + i, '0, '0);
        check("refill_out", 128'({out_valid, out_data}), 128'({1'b1, 32'h7000_0001}));

        // Saturation
        cycle(1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 32'h9000_0000 + i, 4'b0001, 4'b0000);
        check("sat_stall", 128'(stall_cnt), 128'(CMAX));

        // Random traffic
        cycle(1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 400; i++) begin
            logic [STAGES-1:0] st, fl;
            st = '0; fl = '0;
            for (int k = 0; k < STAGES; k++) begin
                st[k] = ($urandom_range(0, 7) == 0);
                fl[k] = ($urandom_range(0, 11) == 0);
            end
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom, st, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
